comb_sequencer: RTL and testbench
=================================

COMB_SEQUENCER -- requirements
Module: comb_sequencer

Interface
REQ-001 Parameter KEY_W, default 2, width of the key stimulus bus.
REQ-002 Parameter LED_W, default 10, width of the led response bus.
REQ-003 Parameter DW_W, default 16, width of the dwell count.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  run request; sampled only in IDLE.
REQ-007 stop  input  1  abort request; honoured in any state.
REQ-008 loop  input  1  1 = restart at key 0 after last key; sampled at start.
REQ-009 dwell  input  DW_W  cycles each key value is held; sampled at start.
REQ-010 key_o  output  KEY_W  stimulus to the combinational block under control.
REQ-011 led_i  input  LED_W  response from the combinational block.
REQ-012 sample_valid  output  1  one-cycle pulse: sample_key/sample_led updated.
REQ-013 sample_key  output  KEY_W  key value that produced sample_led.
REQ-014 sample_led  output  LED_W  captured led_i.
REQ-015 sig  output  LED_W  running signature of all samples in the current run.
REQ-016 busy  output  1  high in DRIVE.
REQ-017 done  output  1  one-cycle pulse at normal run completion.

Function
REQ-018 FSM states SHALL be IDLE, DRIVE, DONE.
REQ-019 IDLE -> DRIVE on start=1 and stop=0; start with stop=1 SHALL stay IDLE.
REQ-020 On entering DRIVE, key_o SHALL be 0, sig SHALL clear to 0, dwell and loop latched; effective dwell D = max(dwell,1).
REQ-021 Each key value SHALL be driven on key_o for exactly D consecutive cycles.
REQ-022 At the edge ending the D-th cycle: sample_led<=led_i, sample_key<=key_o, sig<={sig[LED_W-2:0],sig[LED_W-1]}^led_i, sample_valid=1 in the following cycle.
REQ-023 key_o SHALL increment at that same edge, wrapping 2^KEY_W-1 -> 0.
REQ-024 After sampling key 2^KEY_W-1 with latched loop=0: DRIVE -> DONE; key_o=0, done=1 and the final sample_valid=1 in the same cycle; DONE -> IDLE next cycle unconditionally.
REQ-025 With latched loop=1, sampling SHALL continue indefinitely; sig keeps accumulating across wraps.
REQ-026 stop=1 in DRIVE SHALL go to IDLE next cycle: key_o=0, no sample_valid, no done; sig and sample_* hold last values.
REQ-027 stop and a sample edge coinciding: stop wins, sample discarded.
REQ-028 start while busy or in DONE SHALL be ignored; dwell/loop changes mid-run SHALL have no effect.
REQ-029 Counter arithmetic SHALL be DW_W bits, no overflow for dwell = 2^DW_W-1.
REQ-030 busy=1 exactly in DRIVE; non-loop run SHALL keep busy high for 4*D cycles (KEY_W=2).

Reset
REQ-031 rst=1 SHALL force IDLE, key_o=0, sample_valid=0, sample_key=0, sample_led=0, sig=0, busy=0, done=0, counter=0, next edge.
REQ-032 rst mid-run SHALL abandon the run with no done pulse; rst has priority over start/stop.

Structure
REQ-033 State encoding and the default widths SHALL live in shared package comb_seq_pkg.
REQ-034 Dwell timer SHALL be a separate sub-module dwell_timer (load, expire pulse); all else in comb_sequencer.

Verification (stub: led_i = {8'b0, key_o})
REQ-035 dwell=1, loop=0, start 1 cycle -> key_o 0,1,2,3 one cycle each; samples (0,0x000),(1,0x001),(2,0x002),(3,0x003); done with last sample; sig=0x003; busy 4 cycles.
REQ-036 dwell=0 -> identical to dwell=1.
REQ-037 dwell=5, loop=0 -> each key held 5 cycles, busy 20 cycles, first sample_valid 6 cycles after start edge.
REQ-038 dwell=2, loop=1, stop after 10 samples -> key wraps 3->0, sample_key sequence 0..3,0..3,0,1; no done; key_o=0 after stop.
REQ-039 start and stop together in IDLE -> stays IDLE, busy=0; start during run -> no restart, sig unaffected.
REQ-040 rst asserted at cycle 3 of dwell=4 run -> all outputs 0 next cycle, no done; fresh start completes normally with sig=0x003.

Source files
------------

// File: rtl/comb_seq_pkg.sv
// comb_seq_pkg
//   Shared definitions for the comb_sequencer block: default bus widths and
//   the sequencer state encoding.
//   No ports.
package comb_seq_pkg;

    localparam int KEY_W_DEF = 2;
    localparam int LED_W_DEF = 10;
    localparam int DW_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer
//   Down-counter that pulses expire_o once every (period_i + 1) enabled
//   cycles. load_i captures a new period and restarts the count.
//   Ports:
//     clk       - clock, rising edge
//     rst       - synchronous active-high reset
//     load_i    - capture period_i and restart the count
//     period_i  - reload value (number of cycles per period minus one)
//     en_i      - count enable
//     expire_o  - high in the last enabled cycle of each period
module dwell_timer #(
    parameter int DW_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [DW_W-1:0] period_i,
    input  logic            en_i,
    output logic            expire_o
);

    localparam logic [DW_W-1:0] ONE = {{(DW_W-1){1'b0}}, 1'b1};

    logic [DW_W-1:0] period_q, period_d;
    logic [DW_W-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == '0);

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            period_d = period_i;
            cnt_d    = period_i;
        end else if (en_i) begin
            // Reloading from the latched period keeps the count at DW_W bits,
            // so a period of 2^DW_W-1 cycles never needs an extra bit.
            cnt_d = (cnt_q == '0) ? period_q : cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/comb_sequencer.sv
// comb_sequencer
//   Walks key_o through every key value, holding each for a programmable
//   dwell, captures the combinational response led_i at the end of each
//   dwell and folds it into a rotating XOR signature.
//   Ports:
//     clk, rst      - clock and synchronous active-high reset
//     start         - run request (IDLE only)
//     stop          - abort request (any state)
//     loop          - keep cycling keys forever (latched at start)
//     dwell         - cycles per key, 0 treated as 1 (latched at start)
//     key_o         - stimulus to the block under control
//     led_i         - response from the block under control
//     sample_valid  - one-cycle pulse, sample_key/sample_led updated
//     sample_key    - key that produced sample_led
//     sample_led    - captured led_i
//     sig           - running signature of the current run
//     busy          - high while driving keys
//     done          - one-cycle pulse at normal completion
//     state_o       - current FSM state, for debug
//
//   Handshake: sample_valid is a pure output strobe with no ready; the
//   consumer must take sample_key/sample_led/sig in the cycle it is high.
module comb_sequencer
    import comb_seq_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int LED_W = LED_W_DEF,
    parameter int DW_W  = DW_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [DW_W-1:0]  dwell,
    output logic [KEY_W-1:0] key_o,
    input  logic [LED_W-1:0] led_i,
    output logic             sample_valid,
    output logic [KEY_W-1:0] sample_key,
    output logic [LED_W-1:0] sample_led,
    output logic [LED_W-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_o
);

    localparam logic [KEY_W-1:0] KEY_ONE = {{(KEY_W-1){1'b0}}, 1'b1};
    localparam logic [DW_W-1:0]  DW_ONE  = {{(DW_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             sv_q, sv_d;
    logic [KEY_W-1:0] skey_q, skey_d;
    logic [LED_W-1:0] sled_q, sled_d;
    logic [LED_W-1:0] sig_q, sig_d;
    logic             loop_q, loop_d;

    logic             start_run;
    logic             expire;
    logic [DW_W-1:0]  period;

    // dwell of 0 behaves as 1; the timer wants cycles-minus-one.
    assign period = (dwell == '0) ? '0 : dwell - DW_ONE;

    dwell_timer #(
        .DW_W(DW_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (start_run),
        .period_i(period),
        .en_i    (state_q == DRIVE),
        .expire_o(expire)
    );

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        sv_d      = 1'b0;
        skey_d    = skey_q;
        sled_d    = sled_q;
        sig_d     = sig_q;
        loop_d    = loop_q;
        start_run = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d   = DRIVE;
                    key_d     = '0;
                    sig_d     = '0;
                    loop_d    = loop;
                    start_run = 1'b1;
                end
            end
            DRIVE: begin
                // stop beats a coinciding sample edge: nothing is captured.
                if (stop) begin
                    state_d = IDLE;
                    key_d   = '0;
                end else if (expire) begin
                    sv_d   = 1'b1;
                    skey_d = key_q;
                    sled_d = led_i;
                    sig_d  = {sig_q[LED_W-2:0], sig_q[LED_W-1]} ^ led_i;
                    key_d  = key_q + KEY_ONE;
                    if ((key_q == '1) && !loop_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                key_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            sv_q    <= 1'b0;
            skey_q  <= '0;
            sled_q  <= '0;
            sig_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            sv_q    <= sv_d;
            skey_q  <= skey_d;
            sled_q  <= sled_d;
            sig_q   <= sig_d;
            loop_q  <= loop_d;
        end
    end

    assign key_o        = key_q;
    assign sample_valid = sv_q;
    assign sample_key   = skey_q;
    assign sample_led   = sled_q;
    assign sig          = sig_q;
    assign busy         = (state_q == DRIVE);
    assign done         = (state_q == DONE);
    assign state_o      = state_q;

endmodule

// File: tb/tb_comb_sequencer.sv
module tb_comb_sequencer;

    localparam int KEY_W = 2;
    localparam int LED_W = 10;
    localparam int DW_W  = 16;
    localparam int NKEY  = 4;
    localparam int EW    = 1 + KEY_W + 2 * LED_W;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             loop;
    logic [DW_W-1:0]  dwell;
    logic [KEY_W-1:0] key_o;
    logic [LED_W-1:0] led_i;
    logic             sample_valid;
    logic [KEY_W-1:0] sample_key;
    logic [LED_W-1:0] sample_led;
    logic [LED_W-1:0] sig;
    logic             busy;
    logic             done;
    logic [1:0]       state_o;

    // expected entry: {last, key, led, sig}
    logic [EW-1:0]    exp_q[$];
    int               tests;
    int               fails;
    logic [LED_W-1:0] model_sig;

    comb_sequencer #(
        .KEY_W(KEY_W),
        .LED_W(LED_W),
        .DW_W (DW_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .loop        (loop),
        .dwell       (dwell),
        .key_o       (key_o),
        .led_i       (led_i),
        .sample_valid(sample_valid),
        .sample_key  (sample_key),
        .sample_led  (sample_led),
        .sig         (sig),
        .busy        (busy),
        .done        (done),
        .state_o     (state_o)
    );

    // stub combinational block
    assign led_i = {{(LED_W-KEY_W){1'b0}}, key_o};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] v);
        return {v[LED_W-2:0], v[LED_W-1]};
    endfunction

    // Reference: the n samples of a run are keys 0,1,2,3,0,... in order; the
    // stub answers key k with led value k; signature is rotate-left then XOR.
    task automatic push_samples(input int n, input bit nonloop);
        logic [KEY_W-1:0] k;
        logic [LED_W-1:0] led;
        for (int i = 0; i < n; i++) begin
            k         = KEY_W'(i % NKEY);
            led       = LED_W'(i % NKEY);
            model_sig = rotl(model_sig) ^ led;
            exp_q.push_back({(nonloop && (i == n - 1)), k, led, model_sig});
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_sample: got key 0x%0h led 0x%0h expected no sample at %0t",
                             sample_key, sample_led, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_key", 32'(sample_key), 32'(e[2*LED_W +: KEY_W]));
                    check("sample_led", 32'(sample_led), 32'(e[LED_W +: LED_W]));
                    check("sig",        32'(sig),        32'(e[0 +: LED_W]));
                    check("done_with_sample", 32'(done), 32'(e[EW-1]));
                end
            end else if (done) begin
                check("done_without_sample", 32'(done), 32'd0);
            end
        end
    end

    // driver tasks
    task automatic run_normal(input int d, input bit perturb);
        int  dd;
        int  cyc;
        int  busy_cnt;
        int  first;
        bit  got_done;
        dd = (d == 0) ? 1 : d;
        @(negedge clk);
        dwell     = DW_W'(d);
        loop      = 1'b0;
        start     = 1'b1;
        stop      = 1'b0;
        model_sig = '0;
        push_samples(NKEY, 1'b1);
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        first    = 0;
        got_done = 1'b0;
        while (!got_done && cyc <= NKEY * dd + 10) begin
            if (busy) begin
                busy_cnt++;
                check("key_o", 32'(key_o), 32'(((cyc - 1) / dd) % NKEY));
            end
            if (sample_valid && first == 0) first = cyc;
            if (done) begin
                got_done = 1'b1;
                check("key_at_done", 32'(key_o), 32'd0);
            end
            if (perturb && cyc == 2) begin
                start = 1'b1;
                dwell = dwell + DW_W'(3);
                loop  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        loop  = 1'b0;
        check("run_done_seen", 32'(got_done), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(NKEY * dd));
        check("first_sample_cycle", 32'(first), 32'(dd + 1));
        @(negedge clk);
        check("idle_after_done_busy", 32'(busy), 32'd0);
        check("idle_after_done_state", 32'(state_o), 32'd0);
    endtask

    task automatic run_loop_stop();
        int seen;
        int cnt;
        @(negedge clk);
        dwell     = DW_W'(2);
        loop      = 1'b1;
        start     = 1'b1;
        model_sig = '0;
        push_samples(10, 1'b0);
        @(negedge clk);
        start = 1'b0;
        loop  = 1'b0;
        seen  = 0;
        cnt   = 0;
        while (seen < 10 && cnt < 200) begin
            if (sample_valid) seen++;
            if (seen < 10) begin
                @(negedge clk);
                cnt++;
            end
        end
        check("loop_samples_seen", 32'(seen), 32'd10);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("loop_stop_busy", 32'(busy), 32'd0);
        check("loop_stop_key", 32'(key_o), 32'd0);
        check("loop_stop_done", 32'(done), 32'd0);
        check("loop_stop_sig_hold", 32'(sig), 32'(model_sig));
        check("loop_stop_skey_hold", 32'(sample_key), 32'd1);
        repeat (5) @(negedge clk);
        check("loop_stop_still_idle", 32'(state_o), 32'd0);
    endtask

    // stop lands on the edge that would sample key 0: no sample may appear
    task automatic run_stop_on_sample();
        logic [KEY_W-1:0] prev_key;
        logic [LED_W-1:0] prev_led;
        prev_key = sample_key;
        prev_led = sample_led;
        @(negedge clk);
        dwell     = DW_W'(3);
        loop      = 1'b0;
        start     = 1'b1;
        model_sig = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("coinc_busy", 32'(busy), 32'd0);
        check("coinc_sv", 32'(sample_valid), 32'd0);
        check("coinc_key", 32'(key_o), 32'd0);
        check("coinc_sig_cleared", 32'(sig), 32'd0);
        check("coinc_skey_hold", 32'(sample_key), 32'(prev_key));
        check("coinc_sled_hold", 32'(sample_led), 32'(prev_led));
        repeat (4) @(negedge clk);
    endtask

    task automatic run_start_stop_idle();
        @(negedge clk);
        dwell = DW_W'(1);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("ss_idle_busy", 32'(busy), 32'd0);
        check("ss_idle_state", 32'(state_o), 32'd0);
        repeat (2) @(negedge clk);
        check("ss_idle_busy_later", 32'(busy), 32'd0);
    endtask

    task automatic run_reset_mid();
        @(negedge clk);
        dwell = DW_W'(4);
        loop  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_key", 32'(key_o), 32'd0);
        check("rst_sv", 32'(sample_valid), 32'd0);
        check("rst_skey", 32'(sample_key), 32'd0);
        check("rst_sled", 32'(sample_led), 32'd0);
        check("rst_sig", 32'(sig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        model_sig = '0;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        loop      = 1'b0;
        dwell     = '0;
        repeat (3) @(negedge clk);
        check("reset_key", 32'(key_o), 32'd0);
        check("reset_sv", 32'(sample_valid), 32'd0);
        check("reset_sig", 32'(sig), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_normal(1, 1'b0);
        run_normal(0, 1'b0);
        run_normal(5, 1'b0);
        run_normal(2, 1'b1);
        repeat (3) run_normal(int'($urandom_range(1, 7)), 1'b0);
        run_loop_stop();
        run_stop_on_sample();
        run_start_stop_idle();
        run_reset_mid();
        run_normal(4, 1'b0);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
